apb_master_arbiter: RTL

//  APB master that shares one APB slave between two requesters (round-robin).

---
 rtl/apb_master_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Purpose  : APB master shared by two requesters with round-robin arbitration.
//            A granted request is latched onto PWRITE/PRWADDR/PRWDATA, driven
//            through the SETUP and ACCESS phases, and completed on PREADY or
//            on an ACCESS-phase timeout. Read data and status are returned to
//            the requester that owned the transfer.
// Ports    : PCLK, PRESETn            clock, async active-low reset
//            reqN_valid/write/addr/wdata  request from requester N (0/1)
//            reqN_ack                 1-cycle acceptance pulse to requester N
//            rsp_valid/id/rdata/err   completion pulse, owner, data, timeout
//            PSEL/PENABLE/PWRITE/PRWADDR/PRWDATA  APB request side
//            PRDATA1/PREADY           APB slave response side
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    // requester 0
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    // requester 1
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    // response
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PRWADDR,
    output logic [DATA_W-1:0] PRWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic              PREADY
);

    localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_last_grant;
    logic              r_owner;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_praddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_any_valid;
    logic              w_gnt_id;
    logic              w_grant;
    logic              w_done;
    logic              w_timeout;

    assign w_any_valid = req0_valid | req1_valid;
    // With both requesters pending, the one that did not win last time wins.
    assign w_gnt_id    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_done      = (r_state == ST_ACCESS) & (PREADY | w_timeout);

    // ------------------------------------------------------------------
    // ACCESS-phase timeout: the counter is zero on the first ACCESS cycle
    // (every ACCESS is entered from SETUP), so a value of TIMEOUT-1 marks
    // the last permitted ACCESS cycle.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam logic [c_CNT_W-1:0] c_TMAX  = c_CNT_W'(TIMEOUT);
            localparam logic [c_CNT_W-1:0] c_TLAST = c_CNT_W'(TIMEOUT - 1);
            logic [c_CNT_W-1:0] r_tcnt;

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    r_tcnt <= '0;
                end else if (r_state != ST_ACCESS) begin
                    r_tcnt <= '0;
                end else if (r_tcnt != c_TMAX) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end

            assign w_timeout = (r_state == ST_ACCESS) & (r_tcnt == c_TLAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and phase outputs. PSEL/PENABLE decode straight from the
    // state register so an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL        = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (w_done) begin
                    // Back-to-back: a pending request is taken in the
                    // completion cycle so PSEL stays high into SETUP.
                    if (w_any_valid) begin
                        w_grant     = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A requester must never see an acceptance while the block is held in
    // reset, even though the reset state is IDLE.
    assign req0_ack = w_grant & ~w_gnt_id & PRESETn;
    assign req1_ack = w_grant &  w_gnt_id & PRESETn;

    // ------------------------------------------------------------------
    // Request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_pwrite     <= 1'b0;
            r_praddr     <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_gnt_id;
                r_owner      <= w_gnt_id;
                r_pwrite     <= w_gnt_id ? req1_write : req0_write;
                r_praddr     <= w_gnt_id ? req1_addr  : req0_addr;
                r_pwdata     <= w_gnt_id ? req1_wdata : req0_wdata;
            end
            r_rsp_valid <= w_done;
            if (w_done) begin
                // PREADY low here means the completion came from the timeout.
                r_rsp_id    <= r_owner;
                r_rsp_err   <= ~PREADY;
                r_rsp_rdata <= (PREADY & ~r_pwrite) ? PRDATA1 : '0;
            end
        end
    end

    assign PWRITE    = r_pwrite;
    assign PRWADDR   = r_praddr;
    assign PRWDATA   = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
